// File: rtl/spm_driver_pkg.sv
// Shared types and constants for the spm_driver host-side serial-parallel multiplier driver.
// The optional signed-Y mode is selected by SPM_DRIVER_SIGNED_Y_EN.
package spm_driver_pkg;

  localparam int unsigned SPM_SIZE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Bit counter must reach 2*size-1 with headroom.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(2 * size) + 1;
  endfunction

endpackage

// File: rtl/spm_driver_deser.sv
// Right-shifting capture register: collects the serial product LSB-first into a parallel word.
module spm_driver_deser #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[W-1:1]};
    end
  end

endmodule

// File: rtl/spm_driver.sv
// Drives one spm instance: holds x, streams y LSB-first, deserialises the product.
// Define SPM_DRIVER_SIGNED_Y_EN to sign-extend y and expose the signed_mode tie-off.
module spm_driver
  import spm_driver_pkg::*;
#(
  parameter int unsigned SIZE = SPM_SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_x,
  input  logic [SIZE-1:0]   in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_p,
  output logic              busy,
  output logic              spm_rst,
  output logic [SIZE-1:0]   spm_x,
  output logic              spm_y,
  input  logic              spm_p
`ifdef SPM_DRIVER_SIGNED_Y_EN
  ,
  output logic              signed_mode
`endif
);

  localparam int unsigned PW = 2 * SIZE;
  localparam int unsigned CW = cnt_width(SIZE);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] x_q, x_d;
  logic [SIZE-1:0] y_q, y_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            spm_rst_q, spm_rst_d;
  logic            cap_en, cap_clr;
  logic            fill_bit;

  // Arithmetic shift keeps the latched sign bit, so no extra fill register is needed.
`ifdef SPM_DRIVER_SIGNED_Y_EN
  assign fill_bit    = y_q[SIZE-1];
  assign signed_mode = 1'b1;
`else
  assign fill_bit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      spm_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      spm_rst_q   <= spm_rst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    spm_rst_d   = spm_rst_q;
    cap_en      = 1'b0;
    cap_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = RUN;
          x_d        = in_x;
          y_d        = in_y;
          cnt_d      = '0;
          cap_clr    = 1'b1;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          spm_rst_d  = 1'b0;
        end
      end
      RUN: begin
        // Product bit k appears one edge after y bit k, so capture lags by one.
        y_d    = {fill_bit, y_q[SIZE-1:1]};
        cap_en = (cnt_q != '0);
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(PW - 1)) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        cap_en      = 1'b1;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          spm_rst_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  spm_driver_deser #(
    .W (PW)
  ) u_deser (
    .clk (clk),
    .rst (rst),
    .en  (cap_en),
    .clr (cap_clr),
    .din (spm_p),
    .q   (out_p)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign spm_rst   = spm_rst_q;
  assign spm_x     = x_q;
  assign spm_y     = y_q[0];

endmodule

// File: tb/tb_spm_driver.sv
// Self-checking bench for spm_driver (SIZE=8) with a behavioural serial-parallel multiplier.
module tb_spm_driver;

  localparam int unsigned SZ = 8;
`ifdef SPM_DRIVER_SIGNED_Y_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SZ-1:0] in_x, in_y;
  logic          out_valid;
  logic          out_ready;
  logic [2*SZ-1:0] out_p;
  logic          busy;
  logic          spm_rst;
  logic [SZ-1:0] spm_x;
  logic          spm_y;
  logic          spm_p;
`ifdef SPM_DRIVER_SIGNED_Y_EN
  logic          signed_mode;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spm_driver #(.SIZE(SZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .spm_rst   (spm_rst),
    .spm_x     (spm_x),
    .spm_y     (spm_y),
    .spm_p     (spm_p)
`ifdef SPM_DRIVER_SIGNED_Y_EN
    ,
    .signed_mode (signed_mode)
`endif
  );

  // Behavioural spm: product bit k depends only on y bits 0..k, registered one edge after bit k.
  logic [2*SZ-1:0] ys;
  logic [2*SZ-1:0] ptmp;
  int              k;
  always @(posedge clk) begin
    if (spm_rst) begin
      ys = '0;
      k  = 0;
      spm_p <= 1'b0;
    end else if (k < 2 * SZ) begin
      ys[k] = spm_y;
      ptmp  = 16'(longint'($signed(spm_x)) * longint'(ys));
      spm_p <= ptmp[k];
      k++;
    end
  end

  function automatic logic [2*SZ-1:0] model(input logic [SZ-1:0] x, input logic [SZ-1:0] y);
    longint a, b;
    a = longint'($signed(x));
    b = SGN ? longint'($signed(y)) : longint'(y);
    return 16'(a * b);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; entered and left on a negedge.
  task automatic run_op(input logic [SZ-1:0] x, input logic [SZ-1:0] y,
                        input logic [2*SZ-1:0] exp_p, input int hold, input string tag);
    int n;
    bit busy_ok, hold_ok;
    logic [2*SZ-1:0] held;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_x = x; in_y = y; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_x = SZ'($urandom); in_y = SZ'($urandom);
    n = 0; busy_ok = 1'b1;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (!busy) busy_ok = 1'b0;
    end while (!out_valid && n < 100);
    check({tag, "_lat"}, 32'(n), 32'(2 * SZ + 1));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_p"}, 32'(out_p), 32'(exp_p));
    held = out_p; hold_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_x = SZ'($urandom); in_y = SZ'($urandom);
      @(posedge clk); #1;
      if (out_p !== held || in_ready !== 1'b0 || out_valid !== 1'b1) hold_ok = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, {28'd0, out_valid, busy, in_ready, spm_rst}, 32'b0011);
  endtask

  initial begin
    logic [SZ-1:0] rx, ry;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    #12;
    check("rst_outs", {21'd0, in_ready, out_valid, busy, spm_rst, spm_y, 6'd0},
          {21'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0});
    check("rst_p", 32'(out_p), 32'd0);
    check("rst_x", 32'(spm_x), 32'd0);
`ifdef SPM_DRIVER_SIGNED_Y_EN
    check("signed_mode", 32'(signed_mode), 32'd1);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd50, 8'hCE, SGN ? 16'hF63C : 16'h283C, 0, "basic");
    run_op(8'hFD, 8'd5, 16'hFFF1, 10, "negx");
    run_op(8'd7, 8'd9, 16'h003F, 0, "after_bp");

    run_op(8'd0, 8'hFF, 16'h0000, 0, "b2b0");
    run_op(8'd127, 8'hFF, SGN ? 16'hFF81 : 16'h7E81, 0, "b2b1");
    run_op(8'h80, 8'hFF, SGN ? 16'h0080 : 16'h8080, 0, "b2b2");

    // Reset while RUN with count at 5.
    in_valid = 1'b1; in_x = 8'd50; in_y = 8'hCE;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_state", {28'd0, out_valid, busy, in_ready, spm_rst}, 32'b0011);
    check("midrst_p", 32'(out_p), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'd12, 8'd12, 16'h0090, 0, "after_rst");

    run_op(8'h7F, 8'd1, 16'h007F, 0, "edge_7f");
    run_op(8'h00, 8'h00, 16'h0000, 0, "edge_00");
    run_op(8'h80, 8'hFF, SGN ? 16'h0080 : 16'h8080, 1, "edge_80");

    for (int i = 0; i < 20; i++) begin
      rx = SZ'($urandom);
      ry = SZ'($urandom);
      run_op(rx, ry, model(rx, ry), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
